// File: rtl/operand_loader_16_pkg.sv
// Shared widths and FSM encoding for the operand loader and the adder tree it feeds.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package operand_loader_16_pkg;

   localparam int OL_DATA_W  = 32;
   localparam int OL_N_LANES = 16;

   // FILL: collecting serial words. FULL: frame presented, waiting for the tree.
   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } ol_state_t;

   // Words per frame: one a word and one b word per lane.
   function automatic int ol_frame_words(input int n_lanes);
      return 2 * n_lanes;
   endfunction

endpackage

// File: rtl/operand_loader_16.sv
// Deserialises a stream of operand words into N_LANES a/b pairs for the adder tree.
// Latency: frame presented 1 cycle after its last word is accepted.
// Backpressure: in_ready drops while a frame is held; no bypass on the release cycle.
module operand_loader_16
   import operand_loader_16_pkg::*;
#(
   parameter int DATA_W  = OL_DATA_W,
   parameter int N_LANES = OL_N_LANES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_valid,
   input  logic                        in_last,
   output logic                        in_ready,
   output logic [N_LANES*DATA_W-1:0]   out_a,
   output logic [N_LANES*DATA_W-1:0]   out_b,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int N_WORDS = ol_frame_words(N_LANES);
   localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   ol_state_t                      r_state;
   logic [IDX_W-1:0]               r_widx;
   logic                           r_in_ready;
   logic                           r_out_valid;
   logic [N_LANES-1:0][DATA_W-1:0] r_a;
   logic [N_LANES-1:0][DATA_W-1:0] r_b;

   logic                           w_in_fire;
   logic                           w_out_fire;
   logic                           w_frame_end;
   logic [IDX_W-1:0]               w_lane;
   logic [N_LANES-1:0]             w_ld_a;
   logic [N_LANES-1:0]             w_ld_b;

   assign w_in_fire   = in_valid && r_in_ready;
   assign w_out_fire  = r_out_valid && out_ready;
   // A frame closes on in_last or on the final lane slot, whichever comes first.
   assign w_frame_end = in_last || (r_widx == LAST_IDX);
   assign w_lane      = r_widx >> 1;

   // Word-index decoder: even words target a[w/2], odd words target b[w/2].
   always_comb begin
      w_ld_a = '0;
      w_ld_b = '0;
      for (int k = 0; k < N_LANES; k++) begin
         w_ld_a[k] = w_in_fire && !r_widx[0] && (w_lane == IDX_W'(k));
         w_ld_b[k] = w_in_fire &&  r_widx[0] && (w_lane == IDX_W'(k));
      end
   end

   // Lane registers: cleared on reset and on frame hand-off so short frames read zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
      end else if (w_out_fire) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         for (int k = 0; k < N_LANES; k++) begin
            if (w_ld_a[k]) r_a[k] <= in_data;
            if (w_ld_b[k]) r_b[k] <= in_data;
         end
      end
   end

   // FILL/FULL control with registered handshake outputs; ready only reopens the cycle after release.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_FILL;
         r_widx      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (r_state == ST_FILL) begin
         if (w_in_fire) begin
            r_widx <= r_widx + 1'b1;
            if (w_frame_end) begin
               r_state     <= ST_FULL;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b1;
            end
         end
      end else begin
         if (w_out_fire) begin
            r_state     <= ST_FILL;
            r_widx      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_a     = r_a;
   assign out_b     = r_b;

endmodule

// File: doc/operand_loader_16.md
OPERAND_LOADER_16 -- requirements
Module: operand_loader_16

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of one operand word.
REQ-002 Parameter N_LANES, default 16, SHALL set the number of a/b operand pairs per frame.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 Port in_data  input  DATA_W  SHALL carry the serial operand word.
REQ-006 Port in_valid  input  1  SHALL flag in_data as valid.
REQ-007 Port in_last  input  1  SHALL mark the final word of a frame; it is qualified by in_valid.
REQ-008 Port in_ready  output  1  SHALL indicate that the block accepts a word this cycle.
REQ-009 Port out_a  output  N_LANES*DATA_W  SHALL hold lanes a0..a(N-1); lane k occupies bits [k*DATA_W +: DATA_W].
REQ-010 Port out_b  output  N_LANES*DATA_W  SHALL hold lanes b0..b(N-1), packed the same way as out_a.
REQ-011 Port out_valid  output  1  SHALL indicate that a complete frame is presented.
REQ-012 Port out_ready  input  1  SHALL be asserted by the adder tree side when it consumes the frame.

Function
REQ-013 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-014 Word index w (0..2N-1) SHALL count accepted words of the current frame; even w SHALL load a[w/2], odd w SHALL load b[w/2].
REQ-015 The FSM SHALL have two states: FILL (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-016 In FILL, accepting word w=2N-1, or any word with in_last=1, SHALL move the FSM to FULL on the next cycle.
REQ-017 In FULL, an output transfer SHALL return the FSM to FILL, reset w to 0, and clear all lanes to zero on the same edge.
REQ-018 In the cycle FULL exits, in_ready SHALL remain 0; there is no same-cycle bypass, so the minimum frame period is 2N+1 cycles.
REQ-019 Short frame (in_last before w=2N-1): unloaded lanes SHALL read zero, so the tree sum is unaffected.
REQ-020 in_last on word 2N-1 SHALL be equivalent to no in_last.
REQ-021 Words arriving after in_last while in FULL SHALL be back-pressured by in_ready=0 and never dropped.
REQ-022 out_a and out_b SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Latency from accepting the last word to out_valid=1 SHALL be exactly 1 cycle.
REQ-024 No arithmetic SHALL be performed on the data; words pass bit-exact, with no sign extension.

Reset
REQ-025 When rst=1, the block SHALL enter FILL with w=0, in_ready=1 on the cycle after reset deasserts, out_valid=0, and out_a=out_b=0.
REQ-026 Reset mid-frame or in FULL SHALL discard the partial or pending frame without producing an output transfer.
REQ-027 rst SHALL take priority over every simultaneous handshake event.

Structure
REQ-028 DATA_W, N_LANES and the FSM state encoding SHALL live in a shared package, used in common with the adder tree.
REQ-029 The block SHALL be a single module with no sub-modules; the lane registers are indexed by w via a decoder.

Verification
REQ-030 Full frame: after reset, drive 32 words, odd-position words=1 and even-position words=2, with no stalls -> out_valid at cycle 33; every a lane=1, every b lane=2; tree sum=0x30.
REQ-031 Short frame: send 4 words 5,6,7,8 with in_last on the 4th -> a0=5, b0=6, a1=7, b1=8, all other lanes=0, out_valid one cycle later.
REQ-032 Output backpressure: hold out_ready=0 for 10 cycles in FULL while in_valid=1 -> in_ready=0 throughout, outputs unchanged; then release -> next frame starts cleanly with w=0.
REQ-033 Input bubbles: insert random in_valid=0 gaps within a 32-word incrementing frame (0..31) -> a[k]=2k, b[k]=2k+1.
REQ-034 Reset mid-frame: assert rst after 10 words, then send a full frame of 0xFFFFFFFF -> only the second frame is presented, with all lanes=0xFFFFFFFF.
REQ-035 Back-to-back frames: keep out_ready=1 constantly -> frames spaced 33 cycles apart, with no lane carry-over between frames.
